// File: rtl/mdio_pkg.sv
// Shared frame constants, field widths and FSM state encoding for the Clause 22 MDIO slave.
package mdio_pkg;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int PHYAD_W    = 5;
  localparam int REGAD_W    = 5;
  localparam int DATA_W     = 16;
  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // Bit indices within the 32-bit frame
  localparam logic [CNT_W-1:0] BIT_OP_LAST    = 5'd3;
  localparam logic [CNT_W-1:0] BIT_REGAD_LAST = 5'd13;
  localparam logic [CNT_W-1:0] BIT_TA0        = 5'd14;
  localparam logic [CNT_W-1:0] BIT_TA1        = 5'd15;
  localparam logic [CNT_W-1:0] BIT_DATA_LAST  = 5'd30;
  localparam logic [CNT_W-1:0] BIT_LAST       = 5'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] BIT_AFTER_ST   = 5'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_WRITE,
    S_READ
  } mdio_state_t;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdio_rd_shifter.sv
// Read-data serializer: parallel-load on TA bit 14 drives 0 for TA bit 15, then data MSB first.
// One-cycle registered output; idles high whenever neither loading nor shifting.
module mdio_rd_shifter
  import mdio_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_mdio_in
);

  logic [DATA_W-1:0] r_sr;
  logic              r_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_out <= 1'b1;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_out <= 1'b0;
    end else if (i_shift) begin
      r_sr  <= {r_sr[DATA_W-2:0], 1'b0};
      r_out <= r_sr[DATA_W-1];
    end else begin
      r_out <= 1'b1;
    end
  end

  assign o_mdio_in = r_out;

endmodule

// File: rtl/mdio_receptor.sv
// PHY-side Clause 22 MDIO slave: decodes ST/OP/PHYAD/REGAD, captures write data, serializes read data.
// ADDR valid the cycle after bit 13; WR_STB/MDIO_DONE pulse the cycle after bit 31; no backpressure.
module mdio_receptor
  import mdio_pkg::*;
(
  input  logic               MDC,
  input  logic               RESET,
  input  logic               MDIO_OUT,
  input  logic               MDIO_OE,
  output logic               MDIO_IN,
  output logic               MDIO_DONE,
  output logic [REGAD_W-1:0] ADDR,
  output logic [DATA_W-1:0]  WR_DATA,
  input  logic [DATA_W-1:0]  RD_DATA,
  output logic               WR_STB
);

  mdio_state_t        r_state;
  mdio_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_hist_vld;
  logic               r_hist;
  logic [3:0]         r_hdr;
  logic [1:0]         r_op;
  logic [DATA_W-2:0]  r_wsr;
  logic [REGAD_W-1:0] r_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_wr_stb;
  logic               r_done;

  logic               w_st_det;
  logic [1:0]         w_op_now;
  logic [REGAD_W-1:0] w_regad;
  logic               w_addr_ld;
  logic               w_wr_commit;
  logic               w_rd_done;
  logic               w_rd_load;
  logic               w_rd_shift;

  // Only a 0 then 1 on consecutive driven edges counts as ST; preamble 1s never match
  assign w_st_det = (r_state == S_IDLE) && MDIO_OE && r_hist_vld && ({r_hist, MDIO_OUT} == ST);
  assign w_op_now = {r_hdr[0], MDIO_OUT};
  assign w_regad  = {r_hdr, MDIO_OUT};

  always_ff @(posedge MDC) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_st_det) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (!MDIO_OE)
          w_state_nxt = S_IDLE;
        else if ((r_cnt == BIT_OP_LAST) && !op_valid(w_op_now))
          w_state_nxt = S_IDLE;
        else if (r_cnt == BIT_REGAD_LAST)
          w_state_nxt = (r_op == OP_WRITE) ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        if (!MDIO_OE || (r_cnt == BIT_LAST)) w_state_nxt = S_IDLE;
      end
      S_READ: begin
        if (r_cnt == BIT_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr_ld   = 1'b0;
    w_wr_commit = 1'b0;
    w_rd_done   = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_shift  = 1'b0;
    case (r_state)
      S_HEADER: w_addr_ld   = MDIO_OE && (r_cnt == BIT_REGAD_LAST);
      S_WRITE:  w_wr_commit = MDIO_OE && (r_cnt == BIT_LAST);
      S_READ: begin
        w_rd_done  = (r_cnt == BIT_LAST);
        w_rd_load  = (r_cnt == BIT_TA0);
        w_rd_shift = (r_cnt >= BIT_TA1) && (r_cnt <= BIT_DATA_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge MDC) begin
    if (RESET) begin
      r_cnt      <= '0;
      r_hist_vld <= 1'b0;
      r_hist     <= 1'b0;
      r_hdr      <= '0;
      r_op       <= '0;
      r_wsr      <= '0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_wr_stb   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_hist_vld <= (r_state == S_IDLE) && !w_st_det && MDIO_OE;
      r_hist     <= MDIO_OUT;

      if (w_st_det)               r_cnt <= BIT_AFTER_ST;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 5'd1;

      if (r_state == S_HEADER) r_hdr <= {r_hdr[2:0], MDIO_OUT};
      if ((r_state == S_HEADER) && (r_cnt == BIT_OP_LAST)) r_op <= w_op_now;
      if (r_state == S_WRITE) r_wsr <= {r_wsr[DATA_W-3:0], MDIO_OUT};

      if (w_addr_ld)   r_addr    <= w_regad;
      if (w_wr_commit) r_wr_data <= {r_wsr, MDIO_OUT};
      r_wr_stb <= w_wr_commit;
      r_done   <= w_wr_commit || w_rd_done;
    end
  end

  mdio_rd_shifter u_rd_shifter (
    .i_clk     (MDC),
    .i_rst     (RESET),
    .i_load    (w_rd_load),
    .i_shift   (w_rd_shift),
    .i_data    (RD_DATA),
    .o_mdio_in (MDIO_IN)
  );

  assign ADDR      = r_addr;
  assign WR_DATA   = r_wr_data;
  assign WR_STB    = r_wr_stb;
  assign MDIO_DONE = r_done;

endmodule

// File: tb/tb_mdio_receptor.sv
// Directed bench for mdio_receptor: write, read, preamble + back-to-back, bad opcode, OE drop, mid-read reset.
module tb_mdio_receptor;

  logic        MDC = 1'b0;
  logic        RESET = 1'b1;
  logic        MDIO_OUT = 1'b0;
  logic        MDIO_OE = 1'b0;
  logic        MDIO_IN;
  logic        MDIO_DONE;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic [15:0] RD_DATA = 16'h0000;
  logic        WR_STB;

  mdio_receptor dut (
    .MDC       (MDC),
    .RESET     (RESET),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .MDIO_IN   (MDIO_IN),
    .MDIO_DONE (MDIO_DONE),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .RD_DATA   (RD_DATA),
    .WR_STB    (WR_STB)
  );

  always #5 MDC = ~MDC;

  int n_cmp = 0;
  int n_mis = 0;
  int n_stb = 0;
  int n_done = 0;
  logic        sampled_in;
  logic [4:0]  addr13;
  logic        ta14, ta15;
  logic [15:0] rd_bits;
  int          stb0, done0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MDC cycle: drive at negedge, note what the station would sample at the coming edge,
  // then look at registered outputs just after the edge.
  task automatic send_bit(input logic oe, input logic b);
    @(negedge MDC);
    MDIO_OE  = oe;
    MDIO_OUT = b;
    sampled_in = MDIO_IN;
    @(posedge MDC);
    #1;
    if (WR_STB === 1'b1)    n_stb++;
    if (MDIO_DONE === 1'b1) n_done++;
  endtask

  task automatic send_frame(input logic [31:0] vec, input int nbits, input int oe_stop);
    for (int i = 0; i < nbits; i++) begin
      send_bit((oe_stop < 0) || (i < oe_stop), vec[31-i]);
      if (i == 13) addr13 = ADDR;
      if (i == 14) ta14 = sampled_in;
      if (i == 15) ta15 = sampled_in;
      if (i >= 16) rd_bits[31-i] = sampled_in;
    end
  endtask

  function automatic logic [31:0] wr_vec(input logic [4:0] regad, input logic [15:0] d);
    return {2'b01, 2'b01, 5'b00001, regad, 2'b10, d};
  endfunction

  function automatic logic [31:0] rd_vec(input logic [4:0] regad);
    return {2'b01, 2'b10, 5'b00001, regad, 2'b11, 16'h0000};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("rst_addr", 32'(ADDR), 32'h0);
    chk("rst_wr_data", 32'(WR_DATA), 32'h0);
    chk("rst_wr_stb", 32'(WR_STB), 32'h0);
    chk("rst_done", 32'(MDIO_DONE), 32'h0);
    chk("rst_mdio_in", 32'(MDIO_IN), 32'h1);
    @(negedge MDC);
    RESET = 1'b0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);

    // Plain write: REGAD 5, data A5C3
    stb0 = n_stb; done0 = n_done;
    send_frame(wr_vec(5'b00101, 16'hA5C3), 32, -1);
    chk("w1_addr13", 32'(addr13), 32'h05);
    chk("w1_wr_stb", 32'(WR_STB), 32'h1);
    chk("w1_done", 32'(MDIO_DONE), 32'h1);
    chk("w1_wr_data", 32'(WR_DATA), 32'hA5C3);
    send_bit(1'b0, 1'b0);
    chk("w1_stb_low", 32'(WR_STB), 32'h0);
    chk("w1_done_low", 32'(MDIO_DONE), 32'h0);
    chk("w1_stb_cnt", 32'(n_stb - stb0), 32'd1);
    chk("w1_done_cnt", 32'(n_done - done0), 32'd1);

    // Plain read: REGAD 1F, RD_DATA ABCD; station releases the line from TA on
    RD_DATA = 16'hABCD;
    stb0 = n_stb; done0 = n_done;
    send_frame(rd_vec(5'b11111), 32, 14);
    chk("r1_addr13", 32'(addr13), 32'h1F);
    chk("r1_ta14_idle", 32'(ta14), 32'h1);
    chk("r1_ta15_zero", 32'(ta15), 32'h0);
    chk("r1_data_bits", 32'(rd_bits), 32'hABCD);
    chk("r1_done", 32'(MDIO_DONE), 32'h1);
    chk("r1_wr_stb", 32'(WR_STB), 32'h0);
    send_bit(1'b0, 1'b0);
    chk("r1_mdio_in_idle", 32'(sampled_in), 32'h1);
    chk("r1_done_cnt", 32'(n_done - done0), 32'd1);
    chk("r1_stb_cnt", 32'(n_stb - stb0), 32'd0);
    chk("r1_wr_data_kept", 32'(WR_DATA), 32'hA5C3);

    // Preamble of 32 ones, then write and read back-to-back
    for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b1);
    RD_DATA = 16'h5A0F;
    stb0 = n_stb; done0 = n_done;
    send_frame(wr_vec(5'b00011, 16'h1234), 32, -1);
    chk("b2b_w_addr13", 32'(addr13), 32'h03);
    chk("b2b_w_stb", 32'(WR_STB), 32'h1);
    chk("b2b_w_data", 32'(WR_DATA), 32'h1234);
    send_frame(rd_vec(5'b00111), 32, 14);
    chk("b2b_r_addr13", 32'(addr13), 32'h07);
    chk("b2b_r_ta15", 32'(ta15), 32'h0);
    chk("b2b_r_bits", 32'(rd_bits), 32'h5A0F);
    chk("b2b_r_done", 32'(MDIO_DONE), 32'h1);
    send_bit(1'b0, 1'b0);
    chk("b2b_stb_cnt", 32'(n_stb - stb0), 32'd1);
    chk("b2b_done_cnt", 32'(n_done - done0), 32'd2);

    // Bad opcode 11 (remainder all ones so nothing re-syncs), then write aborted at bit 20
    stb0 = n_stb; done0 = n_done;
    send_frame({2'b01, 2'b11, 28'hFFFFFFF}, 32, -1);
    send_bit(1'b0, 1'b0);
    chk("badop_addr_kept", 32'(ADDR), 32'h07);
    send_frame(wr_vec(5'b01001, 16'hBEEF), 32, 20);
    chk("abort_addr13", 32'(addr13), 32'h09);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("abort_stb_cnt", 32'(n_stb - stb0), 32'd0);
    chk("abort_done_cnt", 32'(n_done - done0), 32'd0);
    chk("abort_wr_data_kept", 32'(WR_DATA), 32'h1234);
    send_frame(wr_vec(5'b00010, 16'h0F0F), 32, -1);
    chk("recover_addr13", 32'(addr13), 32'h02);
    chk("recover_stb", 32'(WR_STB), 32'h1);
    chk("recover_wr_data", 32'(WR_DATA), 32'h0F0F);

    // Reset asserted on bit 20 of a read
    RD_DATA = 16'h8001;
    send_frame(rd_vec(5'b00100), 20, 14);
    chk("rr_addr13", 32'(addr13), 32'h04);
    stb0 = n_stb; done0 = n_done;
    @(negedge MDC);
    RESET = 1'b1;
    @(posedge MDC);
    #1;
    chk("rr_mdio_in", 32'(MDIO_IN), 32'h1);
    chk("rr_addr_reset", 32'(ADDR), 32'h0);
    chk("rr_wr_data_reset", 32'(WR_DATA), 32'h0);
    @(negedge MDC);
    RESET = 1'b0;
    for (int i = 0; i < 14; i++) send_bit(1'b0, 1'b0);
    chk("rr_mdio_in_after", 32'(MDIO_IN), 32'h1);
    chk("rr_done_cnt", 32'(n_done - done0), 32'd0);
    send_frame(wr_vec(5'b00110, 16'hC3C3), 32, -1);
    chk("rr_next_addr13", 32'(addr13), 32'h06);
    chk("rr_next_wr_data", 32'(WR_DATA), 32'hC3C3);
    chk("rr_next_done", 32'(MDIO_DONE), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
